ysyx_23060208_idu_issue: RTL

// Parametrised decode/issue stage for the pipelined NPC core, sitting between the IFU and the EXU.
// - Holds one IFU->IDU slot using the valid/allowin handshake.
// - Decodes register usage and blocks issue on RAW hazards via a per-register pending-write scoreboard.
// - Passes pc/inst plus decoded rs1/rs2/rd/rd_wen to the EXU.
// - Supports flush for redirect.

---
 rtl/ysyx_23060208_idu_issue_if.sv | 41 ++++
 rtl/ysyx_23060208_idu_issue.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_idu_issue_if.sv
// ysyx_23060208_idu_issue_if
// Bundles the three IDU-facing channels of the pipeline:
//   - IFU->IDU slot      : ifu_to_idu_bus {pc, inst}, ifu_to_idu_valid, idu_allowin
//   - redirect / retire  : flush, wb_valid, wb_rd
//   - IDU->EXU issue     : exu_allowin, idu_to_exu_valid, idu_pc, idu_inst,
//                          idu_rs1, idu_rs2, idu_rd, idu_rd_wen, idu_stall
// Modports:
//   slave  - the decode/issue stage itself
//   master - the surrounding pipeline (IFU, EXU, WBU, redirect logic)
interface ysyx_23060208_idu_issue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5
);
    logic [2*DATA_WIDTH-1:0] ifu_to_idu_bus;
    logic                    ifu_to_idu_valid;
    logic                    idu_allowin;
    logic                    flush;
    logic                    wb_valid;
    logic [REG_WIDTH-1:0]    wb_rd;
    logic                    exu_allowin;
    logic                    idu_to_exu_valid;
    logic [DATA_WIDTH-1:0]   idu_pc;
    logic [DATA_WIDTH-1:0]   idu_inst;
    logic [REG_WIDTH-1:0]    idu_rs1;
    logic [REG_WIDTH-1:0]    idu_rs2;
    logic [REG_WIDTH-1:0]    idu_rd;
    logic                    idu_rd_wen;
    logic                    idu_stall;

    modport slave (
        input  ifu_to_idu_bus, ifu_to_idu_valid, flush, wb_valid, wb_rd, exu_allowin,
        output idu_allowin, idu_to_exu_valid, idu_pc, idu_inst, idu_rs1, idu_rs2,
               idu_rd, idu_rd_wen, idu_stall
    );

    modport master (
        output ifu_to_idu_bus, ifu_to_idu_valid, flush, wb_valid, wb_rd, exu_allowin,
        input  idu_allowin, idu_to_exu_valid, idu_pc, idu_inst, idu_rs1, idu_rs2,
               idu_rd, idu_rd_wen, idu_stall
    );
endinterface

// File: rtl/ysyx_23060208_idu_issue.sv
// ysyx_23060208_idu_issue
// Decode/issue stage of the pipelined NPC core, between IFU and EXU.
// Holds one instruction slot, decodes its register usage and keeps it back while any
// source register still has an in-flight write (per-register pending-write counters).
// Ports:
//   clk  - clock
//   rst  - synchronous, active-low reset
//   idu  - slave side of ysyx_23060208_idu_issue_if (slot in, wb retire, issue out)
module ysyx_23060208_idu_issue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned CNT_WIDTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060208_idu_issue_if.slave   idu
);
    localparam int unsigned NR_REGS = 1 << REG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Slot register
    logic                    valid_q;
    logic [2*DATA_WIDTH-1:0] bus_q;

    // Pending-write counters, one per architectural register
    logic [CNT_WIDTH-1:0] cnt_q [NR_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [NR_REGS];

    logic [DATA_WIDTH-1:0] inst;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [REG_WIDTH-1:0]  rs1;
    logic [REG_WIDTH-1:0]  rs2;
    logic [REG_WIDTH-1:0]  rd;
    logic                  is_priv;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  rd_wen;
    logic                  hazard;
    logic                  ready_go;
    logic                  allowin;
    logic                  issue_valid;
    logic                  fire;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign inst   = bus_q[DATA_WIDTH-1:0];
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    // Register fields are truncated to REG_WIDTH (RV32E keeps the low 4 bits)
    assign rs1    = inst[15 +: REG_WIDTH];
    assign rs2    = inst[20 +: REG_WIDTH];
    assign rd     = inst[7 +: REG_WIDTH];

    // ecall/ebreak/mret etc.: SYSTEM with funct3 == 0 touches no GPR
    assign is_priv  = (opcode == OPC_SYSTEM) && (funct3 == 3'b000);

    assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL))
                      && !is_priv;
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign rd_wen   = !((opcode == OPC_STORE) || (opcode == OPC_BRANCH)) && !is_priv
                      && (rd != '0);

    // ------------------------------------------------------------------
    // Hazard and handshake
    // ------------------------------------------------------------------
    // Counters are read as registered; a retire this cycle only helps next cycle.
    // A saturated rd counter also blocks, so the increment on issue can never overflow.
    assign hazard = (uses_rs1 && (cnt_q[rs1] != '0))
                  || (uses_rs2 && (cnt_q[rs2] != '0))
                  || (rd_wen && (cnt_q[rd] == CNT_MAX));

    assign ready_go    = !hazard;
    assign issue_valid = valid_q && ready_go && !idu.flush;
    assign allowin     = !valid_q || (ready_go && idu.exu_allowin) || idu.flush;
    assign fire        = issue_valid && idu.exu_allowin;

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NR_REGS; i++) begin
            logic inc;
            logic dec;
            cnt_d[i] = cnt_q[i];
            inc = fire && rd_wen && (rd == REG_WIDTH'(i));
            dec = idu.wb_valid && (idu.wb_rd == REG_WIDTH'(i));
            // Simultaneous issue and retire on one register cancel out
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec && !inc && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
        // x0 is hardwired; never tracked
        cnt_d[0] = '0;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            bus_q   <= '0;
            for (int i = 0; i < NR_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (allowin) begin
                // A redirect in the accept cycle also kills the incoming slot
                valid_q <= idu.ifu_to_idu_valid && !idu.flush;
                bus_q   <= idu.ifu_to_idu_bus;
            end
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign idu.idu_allowin      = allowin;
    assign idu.idu_to_exu_valid = issue_valid;
    assign idu.idu_pc           = bus_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign idu.idu_inst         = inst;
    assign idu.idu_rs1          = rs1;
    assign idu.idu_rs2          = rs2;
    assign idu.idu_rd           = rd;
    assign idu.idu_rd_wen       = rd_wen;
    assign idu.idu_stall        = valid_q && hazard;

endmodule
